// File: rtl/tmds_rx_decode_align.sv
// TMDS receive channel: word alignment by bitslip search plus TMDS decode.
// Stage 1 registers the deserialized word. Stage 2 decodes it into pixel
// data or control bits. The alignment FSM looks at the stage-1 word.
module tmds_rx_decode_align #(
  parameter int unsigned CTRL_RUN       = 64,
  parameter int unsigned SEARCH_TIMEOUT = 3376,
  parameter int unsigned SLIP_WAIT      = 16,
  parameter int unsigned LOSS_TIMEOUT   = 6752,
  parameter int unsigned CNT_W          = 16
) (
  input  logic       Pixl_CLK,
  input  logic       Rst_Posedge,
  input  logic [9:0] I_Raw_Word,
  output logic       O_Bitslip,
  output logic       O_Locked,
  output logic [3:0] O_Slip_Cnt,
  output logic [7:0] O_Data,
  output logic       O_DE,
  output logic       O_C0,
  output logic       O_C1
);

  localparam logic [CNT_W-1:0] RUN_LIM    = CNT_W'(CTRL_RUN);
  localparam logic [CNT_W-1:0] SEARCH_LIM = CNT_W'(SEARCH_TIMEOUT);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(SLIP_WAIT - 1);
  localparam logic [CNT_W-1:0] LOSS_LIM   = CNT_W'(LOSS_TIMEOUT);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [9:0]       raw_q;
  logic [CNT_W-1:0] run_cnt;
  logic [CNT_W-1:0] run_next;
  logic [CNT_W-1:0] idle_cnt;
  logic [CNT_W-1:0] idle_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_next;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W-1:0] idle_inc;
  logic [3:0]       slip_cnt;
  logic [3:0]       slip_next;
  logic             tok;
  logic [1:0]       tok_ctl;
  logic [7:0]       q;
  logic [7:0]       dec;

  // Counters saturate at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Stage 1: capture the raw deserializer word.
  always_ff @(posedge Pixl_CLK) begin
    if (Rst_Posedge) raw_q <= '0;
    else             raw_q <= I_Raw_Word;
  end

  // Control-token detection on the stage-1 word; tok_ctl is {C1, C0}.
  always_comb begin
    tok     = 1'b1;
    tok_ctl = 2'b00;
    case (raw_q)
      10'b1101010100: tok_ctl = 2'b00;
      10'b0010101011: tok_ctl = 2'b01;
      10'b0101010100: tok_ctl = 2'b10;
      10'b1010101011: tok_ctl = 2'b11;
      default:        tok     = 1'b0;
    endcase
  end

  // TMDS data decode: undo the optional inversion, then the XOR/XNOR chain.
  always_comb begin
    q      = raw_q[9] ? ~raw_q[7:0] : raw_q[7:0];
    dec    = '0;
    dec[0] = q[0];
    for (int unsigned i = 1; i < 8; i++) begin
      dec[i] = raw_q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end
  end

  // Alignment FSM state and counter registers.
  always_ff @(posedge Pixl_CLK) begin
    if (Rst_Posedge) begin
      state    <= ST_SEARCH;
      run_cnt  <= '0;
      idle_cnt <= '0;
      wait_cnt <= '0;
      slip_cnt <= '0;
    end else begin
      state    <= state_next;
      run_cnt  <= run_next;
      idle_cnt <= idle_next;
      wait_cnt <= wait_next;
      slip_cnt <= slip_next;
    end
  end

  // Next-state logic; a token in SEARCH clears the idle count, so it beats a pending slip.
  always_comb begin
    state_next = state;
    run_next   = run_cnt;
    idle_next  = idle_cnt;
    wait_next  = wait_cnt;
    slip_next  = slip_cnt;
    run_inc    = sat_inc(run_cnt);
    idle_inc   = sat_inc(idle_cnt);
    case (state)
      ST_SEARCH: begin
        wait_next = '0;
        if (tok) begin
          idle_next = '0;
          if (run_inc >= RUN_LIM) begin
            state_next = ST_LOCKED;
            run_next   = '0;
          end else begin
            run_next = run_inc;
          end
        end else begin
          run_next = '0;
          if (idle_inc >= SEARCH_LIM) begin
            state_next = ST_SLIP;
            idle_next  = '0;
            slip_next  = (slip_cnt == 4'd9) ? '0 : slip_cnt + 4'd1;
          end else begin
            idle_next = idle_inc;
          end
        end
      end
      ST_SLIP: begin
        state_next = ST_WAIT;
        run_next   = '0;
        idle_next  = '0;
        wait_next  = '0;
      end
      ST_WAIT: begin
        run_next  = '0;
        idle_next = '0;
        if (wait_cnt >= WAIT_LAST) begin
          state_next = ST_SEARCH;
          wait_next  = '0;
        end else begin
          wait_next = sat_inc(wait_cnt);
        end
      end
      ST_LOCKED: begin
        run_next  = '0;
        wait_next = '0;
        if (tok) begin
          idle_next = '0;
        end else if (idle_inc >= LOSS_LIM) begin
          state_next = ST_SEARCH;
          idle_next  = '0;
        end else begin
          idle_next = idle_inc;
        end
      end
      default: begin
        state_next = ST_SEARCH;
        run_next   = '0;
        idle_next  = '0;
        wait_next  = '0;
      end
    endcase
  end

  // Status outputs registered from the next state so they line up with the state register.
  always_ff @(posedge Pixl_CLK) begin
    if (Rst_Posedge) begin
      O_Bitslip <= 1'b0;
      O_Locked  <= 1'b0;
    end else begin
      O_Bitslip <= (state_next == ST_SLIP);
      O_Locked  <= (state_next == ST_LOCKED);
    end
  end

  assign O_Slip_Cnt = slip_cnt;

  // Stage 2: decoded outputs. DE tracks the lock flag of the same cycle; C0/C1 hold on data.
  always_ff @(posedge Pixl_CLK) begin
    if (Rst_Posedge) begin
      O_Data <= '0;
      O_DE   <= 1'b0;
      O_C0   <= 1'b0;
      O_C1   <= 1'b0;
    end else if (tok) begin
      O_Data <= '0;
      O_DE   <= 1'b0;
      O_C0   <= tok_ctl[0];
      O_C1   <= tok_ctl[1];
    end else begin
      O_Data <= dec;
      O_DE   <= (state_next == ST_LOCKED);
    end
  end

endmodule
